// File: rtl/lcd_page_scheduler.sv
// Shares the lcd_16x2 driver between an alarm page and a status page: fixed-priority
// arbitration, stable row latches, busy handshake, periodic re-send and a transfer watchdog.
module lcd_page_scheduler #(
  parameter int REFRESH_CYCLES = 500000,
  parameter int TIMEOUT_CYCLES = 200000,
  parameter int CNT_W          = 20
) (
  input  logic         clk_1MHz,
  input  logic         rst_n,
  input  logic         alarm_req,
  input  logic [127:0] alarm_row1,
  input  logic [127:0] alarm_row2,
  input  logic         status_req,
  input  logic [127:0] status_row1,
  input  logic [127:0] status_row2,
  input  logic         lcd_busy,
  output logic         lcd_ena,
  output logic [127:0] row1,
  output logic [127:0] row2,
  output logic         alarm_ack,
  output logic         status_ack,
  output logic         active_src,
  output logic         timeout_err
);

  localparam logic [CNT_W-1:0] REFRESH_LAST = CNT_W'(REFRESH_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [127:0]     SPACES       = {16{8'h20}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ENA  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t           state_q;
  logic             lcd_ena_q;
  logic [127:0]     row1_q;
  logic [127:0]     row2_q;
  logic             alarm_ack_q;
  logic             status_ack_q;
  logic             active_src_q;
  logic             timeout_err_q;
  logic             refresh_pending_q;
  logic [CNT_W-1:0] refresh_cnt_q;
  logic [CNT_W-1:0] timeout_cnt_q;

  logic             grant;
  logic             src_d;
  logic [127:0]     row1_d;
  logic [127:0]     row2_d;
  logic [CNT_W-1:0] refresh_cnt_d;
  logic [CNT_W-1:0] timeout_cnt_d;
  logic             refresh_last;
  logic             timeout_hit;

  // A refresh grant re-sends whichever source was captured last.
  always_comb begin
    grant         = 1'b0;
    src_d         = active_src_q;
    row1_d        = row1_q;
    row2_d        = row2_q;
    refresh_last  = (refresh_cnt_q == REFRESH_LAST);
    timeout_hit   = (timeout_cnt_q == TIMEOUT_LAST);
    refresh_cnt_d = refresh_last ? refresh_cnt_q : refresh_cnt_q + 1'b1;
    timeout_cnt_d = timeout_cnt_q + 1'b1;
    if (state_q == IDLE && !lcd_busy && (alarm_req || status_req || refresh_pending_q)) begin
      grant = 1'b1;
    end
    if (alarm_req) begin
      src_d = 1'b1;
    end else if (status_req) begin
      src_d = 1'b0;
    end
    row1_d = src_d ? alarm_row1 : status_row1;
    row2_d = src_d ? alarm_row2 : status_row2;
  end

  always_ff @(posedge clk_1MHz) begin
    if (!rst_n) begin
      state_q           <= IDLE;
      lcd_ena_q         <= 1'b0;
      row1_q            <= SPACES;
      row2_q            <= SPACES;
      alarm_ack_q       <= 1'b0;
      status_ack_q      <= 1'b0;
      active_src_q      <= 1'b0;
      timeout_err_q     <= 1'b0;
      refresh_pending_q <= 1'b0;
      refresh_cnt_q     <= '0;
      timeout_cnt_q     <= '0;
    end else begin
      alarm_ack_q  <= 1'b0;
      status_ack_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant) begin
            row1_q            <= row1_d;
            row2_q            <= row2_d;
            active_src_q      <= src_d;
            alarm_ack_q       <= alarm_req;
            status_ack_q      <= !alarm_req && status_req;
            lcd_ena_q         <= 1'b1;
            refresh_pending_q <= 1'b0;
            timeout_cnt_q     <= '0;
            state_q           <= ENA;
          end else begin
            refresh_cnt_q <= refresh_cnt_d;
            if (refresh_last) begin
              refresh_pending_q <= 1'b1;
            end
          end
        end
        ENA: begin
          if (timeout_hit) begin
            lcd_ena_q     <= 1'b0;
            timeout_err_q <= 1'b1;
            refresh_cnt_q <= '0;
            state_q       <= IDLE;
          end else begin
            timeout_cnt_q <= timeout_cnt_d;
            if (lcd_busy) begin
              lcd_ena_q <= 1'b0;
              state_q   <= WAIT;
            end
          end
        end
        WAIT: begin
          if (timeout_hit) begin
            lcd_ena_q     <= 1'b0;
            timeout_err_q <= 1'b1;
            refresh_cnt_q <= '0;
            state_q       <= IDLE;
          end else begin
            timeout_cnt_q <= timeout_cnt_d;
            if (!lcd_busy) begin
              refresh_cnt_q <= '0;
              state_q       <= IDLE;
            end
          end
        end
        default: begin
          lcd_ena_q <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  assign lcd_ena     = lcd_ena_q;
  assign row1        = row1_q;
  assign row2        = row2_q;
  assign alarm_ack   = alarm_ack_q;
  assign status_ack  = status_ack_q;
  assign active_src  = active_src_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_lcd_page_scheduler.sv
// Directed bench for lcd_page_scheduler with short refresh/timeout periods.
module tb_lcd_page_scheduler;

  localparam logic [127:0] SPACES = {16{8'h20}};
  localparam logic [127:0] TEMP_S = "TEMP  4.0C      ";
  localparam logic [127:0] ST2    = "DOOR CLOSED     ";
  localparam logic [127:0] ST_A   = "STATUS A        ";
  localparam logic [127:0] ST_B   = "STATUS B        ";
  localparam logic [127:0] ALM1   = "ALARM HIGH TEMP ";
  localparam logic [127:0] ALM2   = "ZONE 3          ";
  localparam logic [127:0] ALM1B  = "ALARM DOOR OPEN ";
  localparam logic [127:0] ALM2B  = "ZONE 7          ";

  logic         clk = 1'b0;
  logic         rst_n;
  logic         alarm_req;
  logic [127:0] alarm_row1;
  logic [127:0] alarm_row2;
  logic         status_req;
  logic [127:0] status_row1;
  logic [127:0] status_row2;
  logic         lcd_busy;
  logic         lcd_ena;
  logic [127:0] row1;
  logic [127:0] row2;
  logic         alarm_ack;
  logic         status_ack;
  logic         active_src;
  logic         timeout_err;

  int checks = 0;
  int errors = 0;

  lcd_page_scheduler #(
    .REFRESH_CYCLES(100),
    .TIMEOUT_CYCLES(50),
    .CNT_W(20)
  ) dut (
    .clk_1MHz   (clk),
    .rst_n      (rst_n),
    .alarm_req  (alarm_req),
    .alarm_row1 (alarm_row1),
    .alarm_row2 (alarm_row2),
    .status_req (status_req),
    .status_row1(status_row1),
    .status_row2(status_row2),
    .lcd_busy   (lcd_busy),
    .lcd_ena    (lcd_ena),
    .row1       (row1),
    .row2       (row2),
    .alarm_ack  (alarm_ack),
    .status_ack (status_ack),
    .active_src (active_src),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Busy high for one cycle, then low: ENA -> WAIT -> IDLE.
  task automatic xfer_done;
    lcd_busy = 1'b1;
    tick();
    lcd_busy = 1'b0;
    tick();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ena"},   128'(lcd_ena), 128'(1'b0));
    chk({tag, "_row1"},  row1, SPACES);
    chk({tag, "_row2"},  row2, SPACES);
    chk({tag, "_aack"},  128'(alarm_ack), 128'(1'b0));
    chk({tag, "_sack"},  128'(status_ack), 128'(1'b0));
    chk({tag, "_src"},   128'(active_src), 128'(1'b0));
    chk({tag, "_terr"},  128'(timeout_err), 128'(1'b0));
  endtask

  initial begin
    rst_n       = 1'b0;
    alarm_req   = 1'b0;
    status_req  = 1'b0;
    lcd_busy    = 1'b0;
    alarm_row1  = ALM1;
    alarm_row2  = ALM2;
    status_row1 = SPACES;
    status_row2 = SPACES;
    repeat (2) tick();
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    tick();

    // Status transfer with busy rising 3 cycles after ena and lasting 40 cycles
    status_row1 = TEMP_S;
    status_row2 = ST2;
    status_req  = 1'b1;
    tick();
    chk("t1_sack",  128'(status_ack), 128'(1'b1));
    chk("t1_aack",  128'(alarm_ack), 128'(1'b0));
    chk("t1_ena0",  128'(lcd_ena), 128'(1'b1));
    chk("t1_row1",  row1, TEMP_S);
    chk("t1_row2",  row2, ST2);
    chk("t1_src",   128'(active_src), 128'(1'b0));
    status_req = 1'b0;
    tick();
    chk("t1_sack_pulse", 128'(status_ack), 128'(1'b0));
    chk("t1_ena1",  128'(lcd_ena), 128'(1'b1));
    tick();
    chk("t1_ena2",  128'(lcd_ena), 128'(1'b1));
    tick();
    chk("t1_ena3",  128'(lcd_ena), 128'(1'b1));
    lcd_busy = 1'b1;
    tick();
    chk("t1_ena4",  128'(lcd_ena), 128'(1'b0));
    repeat (39) tick();

    // Busy falls; both requests raised together at the same time
    lcd_busy   = 1'b0;
    alarm_row1 = ALM1;
    alarm_row2 = ALM2;
    alarm_req  = 1'b1;
    status_req = 1'b1;
    tick();
    chk("t2_no_ack_in_wait", 128'(alarm_ack), 128'(1'b0));
    chk("t1_src_end", 128'(active_src), 128'(1'b0));
    tick();
    chk("t2_aack",  128'(alarm_ack), 128'(1'b1));
    chk("t2_sack0", 128'(status_ack), 128'(1'b0));
    chk("t2_row1",  row1, ALM1);
    chk("t2_row2",  row2, ALM2);
    chk("t2_src1",  128'(active_src), 128'(1'b1));
    chk("t2_ena",   128'(lcd_ena), 128'(1'b1));
    alarm_req = 1'b0;
    tick();
    lcd_busy = 1'b1;
    tick();
    chk("t2_ena_off", 128'(lcd_ena), 128'(1'b0));
    lcd_busy = 1'b0;
    tick();
    chk("t2_sack_wait", 128'(status_ack), 128'(1'b0));
    tick();
    chk("t2_sack",  128'(status_ack), 128'(1'b1));
    chk("t2_row1s", row1, TEMP_S);
    chk("t2_src0",  128'(active_src), 128'(1'b0));
    status_req = 1'b0;
    xfer_done();

    // Alarm transfer, then an automatic refresh with updated alarm rows
    alarm_req = 1'b1;
    tick();
    chk("t3_aack",  128'(alarm_ack), 128'(1'b1));
    alarm_req = 1'b0;
    xfer_done();
    alarm_row1 = ALM1B;
    alarm_row2 = ALM2B;
    repeat (100) tick();
    chk("t3_ena_early", 128'(lcd_ena), 128'(1'b0));
    tick();
    chk("t3_ena",   128'(lcd_ena), 128'(1'b1));
    chk("t3_aack0", 128'(alarm_ack), 128'(1'b0));
    chk("t3_sack0", 128'(status_ack), 128'(1'b0));
    chk("t3_row1",  row1, ALM1B);
    chk("t3_row2",  row2, ALM2B);
    chk("t3_src",   128'(active_src), 128'(1'b1));
    xfer_done();

    // Timeout with busy held low after a grant
    status_row1 = ST_A;
    status_req  = 1'b1;
    tick();
    chk("t4_sack",  128'(status_ack), 128'(1'b1));
    status_req = 1'b0;
    repeat (49) tick();
    chk("t4_ena49", 128'(lcd_ena), 128'(1'b1));
    chk("t4_terr49", 128'(timeout_err), 128'(1'b0));
    tick();
    chk("t4_ena50", 128'(lcd_ena), 128'(1'b0));
    chk("t4_terr",  128'(timeout_err), 128'(1'b1));

    // Source rows change during WAIT; latched rows must hold until next grant
    status_req = 1'b1;
    tick();
    chk("t5_row1",  row1, ST_A);
    status_req = 1'b0;
    lcd_busy   = 1'b1;
    tick();
    status_row1 = ST_B;
    tick();
    chk("t5_row1_wait", row1, ST_A);
    lcd_busy = 1'b0;
    tick();
    chk("t5_row1_idle", row1, ST_A);
    chk("t5_terr_sticky", 128'(timeout_err), 128'(1'b1));
    tick();
    chk("t5_row1_idle2", row1, ST_A);
    status_req = 1'b1;
    tick();
    chk("t5_row1_new", row1, ST_B);
    chk("t5_sack",  128'(status_ack), 128'(1'b1));
    chk("t5_terr2", 128'(timeout_err), 128'(1'b1));
    status_req = 1'b0;

    // Reset during WAIT with a request held high
    lcd_busy = 1'b1;
    tick();
    rst_n      = 1'b0;
    status_req = 1'b1;
    tick();
    chk_reset_outputs("t6_rst");
    tick();
    chk("t6_sack_rst", 128'(status_ack), 128'(1'b0));
    rst_n    = 1'b1;
    lcd_busy = 1'b0;
    tick();
    chk("t6_sack_after", 128'(status_ack), 128'(1'b1));
    chk("t6_row1_after", row1, ST_B);
    status_req = 1'b0;
    xfer_done();

    // Reset during ENA drops lcd_ena on that edge
    alarm_req = 1'b1;
    tick();
    chk("t7_ena",   128'(lcd_ena), 128'(1'b1));
    alarm_req = 1'b0;
    rst_n     = 1'b0;
    tick();
    chk("t7_ena_rst", 128'(lcd_ena), 128'(1'b0));
    chk("t7_row1_rst", row1, SPACES);
    rst_n = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lcd_page_scheduler.md
Name: lcd_page_scheduler

Overview:
Sequences the 16x2 I2C LCD driver (lcd_16x2) and shares it between two page sources: an alarm page and a status page. It arbitrates requests with fixed priority (alarm first) and latches the winning page's 32 characters into stable row registers. It then pulses the driver's enable through a busy handshake and periodically re-sends the current page to recover from LCD glitches. It sits between the cold-storage monitor/alarm logic and lcd_16x2, in the clk_1MHz domain.

Parameters:
REFRESH_CYCLES, 500000, idle cycles after a completed transfer before an automatic re-send of the active page (0.5 s at 1 MHz).
TIMEOUT_CYCLES, 200000, maximum cycles allowed in ENA plus WAIT for one transfer before it is aborted.
CNT_W, 20, width of the refresh and timeout counters; must hold max(REFRESH_CYCLES, TIMEOUT_CYCLES).

Ports:
clk_1MHz  in  1  system clock for the block (1 MHz)
rst_n  in  1  synchronous reset, active low
alarm_req  in  1  level request; held high by the requester until alarm_ack
alarm_row1  in  128  alarm page line 1, 16 ASCII chars, MSB = leftmost
alarm_row2  in  128  alarm page line 2
status_req  in  1  level request; held high until status_ack
status_row1  in  128  status page line 1
status_row2  in  128  status page line 2
lcd_busy  in  1  busy output from lcd_16x2
lcd_ena  out  1  enable input to lcd_16x2
row1  out  128  latched line 1 to lcd_16x2
row2  out  128  latched line 2 to lcd_16x2
alarm_ack  out  1  one-cycle pulse: alarm page captured
status_ack  out  1  one-cycle pulse: status page captured
active_src  out  1  source of the last captured page: 0 = status, 1 = alarm
timeout_err  out  1  sticky: a transfer exceeded TIMEOUT_CYCLES

Behaviour:
- Reset (rst_n = 0 at an edge): state IDLE.
  - lcd_ena, alarm_ack, status_ack, active_src and timeout_err = 0.
  - row1 and row2 = 128'h2020...20 (all spaces).
  - Both counters = 0; refresh_pending = 0.
  - Reset asserted mid-transfer applies identically; lcd_ena drops on that edge.
- States: IDLE, ENA, WAIT.
- IDLE, granting only when lcd_busy = 0. Priority is alarm_req, then status_req, then refresh_pending. On the grant edge:
  - row1/row2 <= the winner's rows. A refresh grant uses the rows of the source selected by active_src.
  - The matching ack = 1 for exactly this one cycle. A refresh grant pulses no ack.
  - active_src <= winner; a refresh grant leaves it unchanged.
  - lcd_ena <= 1; refresh_pending <= 0; timeout counter <= 0; go to ENA.
  - Latency is one cycle from a req being sampled high in IDLE (busy low) to the ack, lcd_ena and new rows.
- ENA: hold lcd_ena = 1 until lcd_busy is sampled 1. On that edge lcd_ena <= 0 and go to WAIT.
- WAIT: when lcd_busy is sampled 0, go to IDLE and clear the refresh counter.
- row1/row2 change only on a grant edge. They are stable throughout ENA and WAIT regardless of source inputs.
- Refresh counter:
  - Increments each cycle in IDLE while no grant occurs, saturating at REFRESH_CYCLES-1.
  - At REFRESH_CYCLES-1 it sets refresh_pending. Any grant clears refresh_pending.
- Timeout counter:
  - Increments each cycle in ENA or WAIT.
  - On reaching TIMEOUT_CYCLES-1: lcd_ena <= 0, timeout_err <= 1 (cleared only by reset), go to IDLE, refresh counter <= 0.
- Simultaneous events:
  - alarm_req and status_req in the same cycle: alarm is granted. status_req stays pending and is granted at the next IDLE grant opportunity.
  - A request and refresh_pending together: the request wins and the refresh is absorbed (pending cleared).
- Requests arriving during ENA or WAIT are not acked until the block returns to IDLE. A request dropped before its ack is simply not served.
- lcd_busy high in IDLE (driver still busy from an external cause): no grant; counters behave as in IDLE.

Test Plan:
- Reset, then status_req = 1 with status_row1 = "TEMP  4.0C      ". Busy model rises 3 cycles after ena and falls 40 cycles later. Expect: status_ack one cycle after the request; row1 = the string; lcd_ena high for exactly 4 cycles; state back to IDLE 1 cycle after busy falls; active_src = 0.
- alarm_req and status_req raised in the same cycle. Expect: alarm_ack first with row1 = alarm_row1; status_ack exactly 1 cycle after the transfer returns to IDLE; active_src ends at 0.
- REFRESH_CYCLES = 100 with no requests after one alarm transfer. Expect: a re-send begins 101 cycles after return to IDLE, no ack pulse, rows = current alarm_row1/row2.
- TIMEOUT_CYCLES = 50 with lcd_busy held 0 after a grant. Expect: lcd_ena falls on the 50th cycle after the grant, timeout_err = 1 and stays 1 across later successful transfers.
- Change status_row1 during WAIT. Expect: row1 unchanged until the next grant.
- rst_n low for one cycle during WAIT. Expect: all outputs at reset values on the next edge; rows read as spaces; no ack pulses.
